// File: rtl/conv_window_gen.sv
// conv_window_gen: raster-order pixel stream to KxK sliding-window generator.
// Keeps K-1 line buffers of IMG_WIDTH pixels and a KxK window register, and
// emits one window per accepted pixel once the window lies fully inside the
// frame (valid convolution, no padding). window_out feeds the multiplier's
// shift_in and window_valid feeds its out_en.
// Optional feature: define CONV_WIN_COUNT_EN to add the window_count output
// (windows emitted in the current frame, saturating at 16'hFFFF).
module conv_window_gen #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    frame_start,
  input  logic                                    pixel_valid,
  input  logic [BITS-1:0]                         pixel_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE*BITS-1:0] window_out,
  output logic                                    window_valid,
  output logic                                    frame_done,
  output logic                                    busy
`ifdef CONV_WIN_COUNT_EN
  ,
  output logic [15:0]                             window_count
`endif
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM
  } state_t;

  state_t          r_state;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_window_valid;
  logic            r_frame_done;
  logic            r_busy;
  logic [BITS-1:0] r_win  [K][K];
  logic [BITS-1:0] r_line [K-1][IMG_WIDTH];

  logic            w_accept;
  logic            w_emit;
  logic            w_last;
  logic [RW-1:0]   w_row_eff;
  logic [CW-1:0]   w_col_eff;
  logic [RW-1:0]   w_row_next;
  logic [CW-1:0]   w_col_next;

  // Acceptance, effective position of this pixel (frame_start forces (0,0)) and the next position.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_accept   = pixel_valid && (frame_start || (r_state != ST_IDLE));
    w_row_eff  = frame_start ? '0 : r_row;
    w_col_eff  = frame_start ? '0 : r_col;
    w_last     = !frame_start && (w_row_eff == ROW_LAST) && (w_col_eff == COL_LAST);
    w_emit     = w_accept && (w_row_eff >= ROW_FIRST) && (w_col_eff >= COL_FIRST);
    w_row_next = w_row_eff;
    w_col_next = w_col_eff + 1'b1;
    if (w_col_eff == COL_LAST) begin
      w_col_next = '0;
      w_row_next = w_row_eff + 1'b1;
    end
  end

  // Frame FSM: state, raster counters and registered strobes.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_row          <= '0;
      r_col          <= '0;
      r_window_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_window_valid <= w_emit;
      r_frame_done   <= 1'b0;
      if (w_accept) begin
        if (w_last) begin
          r_state      <= ST_IDLE;
          r_row        <= '0;
          r_col        <= '0;
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
        end else begin
          r_state <= (w_row_next >= ROW_FIRST) ? ST_STREAM : ST_FILL;
          r_row   <= w_row_next;
          r_col   <= w_col_next;
          r_busy  <= 1'b1;
        end
      end
    end
  end

  // Window register: shift every row left and load the new right column on each accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        r_win[r][K-1] <= r_line[K-2-r][w_col_eff];
      end
      r_win[K-1][K-1] <= pixel_in;
    end
  end

  // Line buffers: newest row enters buffer 0, older rows cascade upward at the same column.
  // NOTE: line-buffer storage has no reset; stale contents are never emitted because emission is counter-gated.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_line[0][w_col_eff] <= pixel_in;
      for (int i = 0; i < K - 2; i++) begin
        r_line[i+1][w_col_eff] <= r_line[i][w_col_eff];
      end
    end
  end

  // Pack the window: element (r,c) at [(r*K+c)*BITS +: BITS], r=0 top row, c=0 left column.
  always_comb begin
    window_out = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        window_out[(r*K+c)*BITS +: BITS] = r_win[r][c];
      end
    end
  end

  assign window_valid = r_window_valid;
  assign frame_done   = r_frame_done;
  assign busy         = r_busy;

`ifdef CONV_WIN_COUNT_EN
  logic [15:0] r_window_count;

  // Windows emitted in the current frame; clears on accepted frame_start, saturates, holds after frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_window_count <= '0;
    end else if (pixel_valid && frame_start) begin
      r_window_count <= '0;
    end else if (w_emit && (r_window_count != 16'hFFFF)) begin
      r_window_count <= r_window_count + 16'd1;
    end
  end

  assign window_count = r_window_count;
`endif

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Raster-order pixel stream to KxK sliding-window generator.
- Its packed window output drives `shift_in` of the convolution multiplier, and `window_valid` drives the multiplier's `out_en`.
- Holds K-1 line buffers of IMG_WIDTH pixels plus a KxK window register.
- Emits one window per accepted pixel once the window lies fully inside the frame (valid convolution only, no padding).

Parameters:
- BITS, 9, pixel width; bits are passed through unmodified, no sign interpretation.
- KERNEL_SIZE, 3, window dimension K (K >= 2).
- IMG_WIDTH, 32, pixels per row (>= K).
- IMG_HEIGHT, 32, rows per frame (>= K).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- frame_start  input  1  qualifies the current pixel as row 0, col 0 of a new frame; ignored unless pixel_valid=1.
- pixel_valid  input  1  pixel_in valid this cycle; no backpressure, every valid pixel is accepted.
- pixel_in  input  BITS  pixel data.
- window_out  output  KERNEL_SIZE*KERNEL_SIZE*BITS  packed window; element (r,c) at bits [(r*K+c)*BITS +: BITS]; r=0 is the oldest (top) row, c=0 is the oldest (left) column.
- window_valid  output  1  one-cycle strobe per window.
- frame_done  output  1  one-cycle strobe after the last pixel of a frame is accepted.
- busy  output  1  high while in FILL or STREAM.

Behaviour:
- Reset: window_out=0, window_valid=0, frame_done=0, busy=0, counters=0, state IDLE. Line-buffer contents are don't-care.
- States:
  - IDLE: ignore pixels until pixel_valid&frame_start. That pixel is accepted as (row 0, col 0) and the state moves to FILL.
  - FILL: accepting pixels while row < K-1.
  - STREAM: row >= K-1; windows are emitted.
  - After the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted: go to IDLE and pulse frame_done the next cycle.
- Counters: col wraps from IMG_WIDTH-1 to 0 and increments row. Counters advance only on accepted pixels.
- Datapath per accepted pixel:
  - Shift each window row left by one.
  - New right column = {line buffer K-2 … line buffer 0 at col, pixel_in}, top to bottom.
  - Write pixel_in into line buffer 0 at col; line buffer i shifts into i+1 at col.
- Window emission:
  - window_valid=1 in the cycle after an accepted pixel with row >= K-1 and col >= K-1.
  - The window then present on window_out has that pixel at (K-1,K-1).
  - Latency is exactly 1 cycle.
- Output holding:
  - window_out holds its value when no pixel is accepted.
  - It may change on accepted pixels that do not produce a window, with window_valid=0.
- pixel_valid low: state, counters and window are frozen; window_valid=0. Gaps of any length do not change the output sequence.
- frame_start while in FILL/STREAM: the current frame is abandoned, counters restart at (0,0) with this pixel, state=FILL, no frame_done.
  - Stale line-buffer data is never emitted, because emission is gated by the counters.
- frame_start on the final pixel of a frame: treated as a restart (the rule above wins); no frame_done.
- Pixels in IDLE without frame_start: dropped, no state change.
- rst_n low mid-frame: everything returns to reset values immediately; any in-flight window_valid is lost.
- Windows per frame: exactly (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1).

Optional Feature:
- Macro: CONV_WIN_COUNT_EN.
- When defined:
  - Adds output window_count [15:0], the number of windows emitted in the current frame.
  - It increments together with window_valid, saturates at 16'hFFFF, clears on accepted frame_start and on reset, and holds after frame_done.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Common setup: K=3, IMG_WIDTH=4, IMG_HEIGHT=4; pixels valued 1..16 in raster order, frame_start on pixel 1, continuous valid.
- Continuous frame:
  - First window_valid one cycle after pixel 11, with rows [1 2 3;5 6 7;9 10 11].
  - Then pixel 12 -> [2 3 4;6 7 8;10 11 12].
  - Pixels 13 and 14 -> no valid.
  - Pixel 15 -> [5 6 7;9 10 11;13 14 15]; pixel 16 -> [6 7 8;10 11 12;14 15 16].
  - frame_done one cycle after pixel 16.
  - 4 windows total; window_count=4 if CONV_WIN_COUNT_EN is defined.
- Random pixel_valid gaps (1–5 idle cycles): identical window sequence and values as the continuous case; window_valid=0 during gaps.
- Restart: frame_start re-asserted on the 7th pixel, followed by 16 pixels of value 100+n.
  - First window [101 102 103;105 106 107;109 110 111] after the 11th new pixel.
  - No window from the stale data; no frame_done for the aborted frame.
- Idle drop: after frame_done, 5 valid pixels with frame_start=0 -> no window_valid, busy=0; the next frame with frame_start behaves as in the continuous-frame case.
- Reset mid-frame: rst_n low after pixel 10 -> all outputs 0 immediately.
  - After release, a fresh frame gives its first window after its 11th pixel.
  - No window is emitted from pre-reset pixels.
